// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Holds the program counter, computes
//                branch targets for conditional (imm19), unconditional
//                (imm26) and register redirects, drives the instruction
//                memory address and registers the fetched instruction into
//                the IF/ID pipeline register with stall and flush control.
//                Optional macro IF_STAGE_PERF_EN adds fetch and redirect
//                event counters (perf_fetched, perf_redirects).
//  Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter int                 ADDR_W    = 64,
  parameter int                 INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redir_valid,
  input  logic [1:0]         redir_type,
  input  logic [ADDR_W-1:0]  redir_pc,
  input  logic [25:0]        redir_imm,
  input  logic [ADDR_W-1:0]  redir_reg,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
`ifdef IF_STAGE_PERF_EN
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_redirects,
`endif
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4
);

  localparam logic [1:0]        c_REDIR_COND   = 2'b00;
  localparam logic [1:0]        c_REDIR_UNCOND = 2'b01;
  localparam logic [ADDR_W-1:0] c_PC_STEP      = ADDR_W'(4);

  logic [ADDR_W-1:0]  r_pc;
  logic               r_id_valid;
  logic [INSTR_W-1:0] r_id_instr;
  logic [ADDR_W-1:0]  r_id_pc;
  logic [ADDR_W-1:0]  r_id_pc_plus4;

  // Word offsets as signed quantities so the width cast sign-extends them;
  // this also works at the minimum ADDR_W of 28 where imm26<<2 fills the bus.
  logic signed [20:0] w_off19;
  logic signed [27:0] w_off26;
  logic [ADDR_W-1:0]  w_target;
  logic [ADDR_W-1:0]  w_pc_plus4;

  assign w_off19    = {redir_imm[18:0], 2'b00};
  assign w_off26    = {redir_imm[25:0], 2'b00};
  assign w_pc_plus4 = r_pc + c_PC_STEP;

  // Redirect target select; the reserved encoding behaves as a register branch.
  always_comb begin
    w_target = redir_reg;
    case (redir_type)
      c_REDIR_COND:   w_target = redir_pc + ADDR_W'(w_off19);
      c_REDIR_UNCOND: w_target = redir_pc + ADDR_W'(w_off26);
      default:        w_target = redir_reg;
    endcase
  end

  // PC and IF/ID register: reset, then redirect (flush), then stall, then advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_id_valid    <= 1'b0;
      r_id_instr    <= NOP_INSTR;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= '0;
    end else if (redir_valid) begin
      r_pc       <= w_target;
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end else if (!stall) begin
      r_pc          <= w_pc_plus4;
      r_id_valid    <= 1'b1;
      r_id_instr    <= imem_rdata;
      r_id_pc       <= r_pc;
      r_id_pc_plus4 <= w_pc_plus4;
    end
  end

`ifdef IF_STAGE_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_redirects;

  // Event counters: a fetch is any edge that loads a valid instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched   <= '0;
      r_perf_redirects <= '0;
    end else if (redir_valid) begin
      r_perf_redirects <= r_perf_redirects + 32'd1;
    end else if (!stall) begin
      r_perf_fetched   <= r_perf_fetched + 32'd1;
    end
  end

  assign perf_fetched   = r_perf_fetched;
  assign perf_redirects = r_perf_redirects;
`endif

  assign imem_addr   = r_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Directed self-checking bench for if_stage (RESET_PC=0x100).
//                Exercises perf counters when IF_STAGE_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] c_NOP = 32'hD503201F;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redir_valid;
  logic [1:0]  redir_type;
  logic [63:0] redir_pc;
  logic [25:0] redir_imm;
  logic [63:0] redir_reg;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [63:0] id_pc_plus4;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_redirects;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  if_stage #(
    .ADDR_W   (64),
    .INSTR_W  (32),
    .RESET_PC (64'h100),
    .NOP_INSTR(c_NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redir_valid(redir_valid),
    .redir_type (redir_type),
    .redir_pc   (redir_pc),
    .redir_imm  (redir_imm),
    .redir_reg  (redir_reg),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
`ifdef IF_STAGE_PERF_EN
    .perf_fetched  (perf_fetched),
    .perf_redirects(perf_redirects),
`endif
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4)
  );

  always #5 clk = ~clk;

  // Instruction memory model: fixed word at 0x100, address-derived elsewhere.
  function automatic logic [31:0] mem(input logic [63:0] a);
    if (a == 64'h100) return 32'h8B020020;
    return a[31:0] ^ 32'h5A5A0000;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [1:0] t, input logic [63:0] pc,
                       input logic [25:0] imm, input logic [63:0] rg);
    redir_valid = 1'b1;
    redir_type  = t;
    redir_pc    = pc;
    redir_imm   = imm;
    redir_reg   = rg;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b0;
    redir_type = 2'b00; redir_pc = '0; redir_imm = '0; redir_reg = '0;
    step(); step();
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_instr", 64'(id_instr), 64'(c_NOP));
    check("rst_pc", id_pc, 64'h0);
    check("rst_pc4", id_pc_plus4, 64'h0);
    check("rst_addr", imem_addr, 64'h100);
`ifdef IF_STAGE_PERF_EN
    check("rst_perf_f", 64'(perf_fetched), 64'd0);
    check("rst_perf_r", 64'(perf_redirects), 64'd0);
`endif

    // First fetch after reset release
    reset = 1'b0;
    step();
    check("f1_valid", 64'(id_valid), 64'd1);
    check("f1_instr", 64'(id_instr), 64'h8B020020);
    check("f1_pc", id_pc, 64'h100);
    check("f1_pc4", id_pc_plus4, 64'h104);
    check("f1_addr", imem_addr, 64'h104);

    // Conditional redirect, imm19 = -1 (upper imm bits must be ignored)
    redir(2'b00, 64'h200, 26'h0A7FFFF, 64'h0);
    step();
    check("cb_addr", imem_addr, 64'h1FC);
    check("cb_valid", 64'(id_valid), 64'd0);
    check("cb_instr", 64'(id_instr), 64'(c_NOP));
    check("cb_pc_hold", id_pc, 64'h100);
    check("cb_pc4_hold", id_pc_plus4, 64'h104);
    redir_valid = 1'b0;
    step();
    check("cb_tgt_valid", 64'(id_valid), 64'd1);
    check("cb_tgt_instr", 64'(id_instr), 64'(mem(64'h1FC)));
    check("cb_tgt_pc", id_pc, 64'h1FC);
    check("cb_tgt_pc4", id_pc_plus4, 64'h200);

    // Unconditional, register, reserved-type (back-to-back), negative imm26
    redir(2'b01, 64'h40, 26'h0000010, 64'h0);
    step();
    check("b_addr", imem_addr, 64'h80);
    redir(2'b10, 64'h40, 26'h0000010, 64'hDEAD0);
    step();
    check("br_addr", imem_addr, 64'hDEAD0);
    redir(2'b11, 64'h40, 26'h0000010, 64'h3000);
    step();
    check("br11_addr", imem_addr, 64'h3000);
    redir(2'b01, 64'h1000, 26'h3FFFFFE, 64'h0);
    step();
    check("b_neg_addr", imem_addr, 64'hFF8);
    check("b_neg_valid", 64'(id_valid), 64'd0);

    // Bring PC to 0x20 with a valid instruction from 0x1C in ID, then stall 3
    redir(2'b10, 64'h0, 26'h0, 64'h1C);
    step();
    redir_valid = 1'b0;
    step();
    check("pre_stall_addr", imem_addr, 64'h20);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", imem_addr, 64'h20);
      check("stall_pc", id_pc, 64'h1C);
      check("stall_instr", 64'(id_instr), 64'(mem(64'h1C)));
      check("stall_valid", 64'(id_valid), 64'd1);
    end
    stall = 1'b0;
    step();
    check("unstall_pc", id_pc, 64'h20);
    check("unstall_addr", imem_addr, 64'h24);

    // Stall together with redirect: redirect wins and inserts a bubble
    stall = 1'b1;
    redir(2'b10, 64'h0, 26'h0, 64'h500);
    step();
    check("sr_addr", imem_addr, 64'h500);
    check("sr_valid", 64'(id_valid), 64'd0);
    redir_valid = 1'b0;
    step();
    check("sr_hold_addr", imem_addr, 64'h500);
    check("sr_hold_valid", 64'(id_valid), 64'd0);
    stall = 1'b0;
    step();
    check("sr_go_pc", id_pc, 64'h500);
    check("sr_go_valid", 64'(id_valid), 64'd1);

    // Wrap at the top of the address space
    redir(2'b10, 64'h0, 26'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    redir_valid = 1'b0;
    step();
    check("wrap_addr", imem_addr, 64'h0);
    check("wrap_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_pc4", id_pc_plus4, 64'h0);

    // Reset during stall and redirect discards everything
    stall = 1'b1;
    redir(2'b10, 64'h0, 26'h0, 64'h777);
    reset = 1'b1;
    step();
    check("mid_rst_addr", imem_addr, 64'h100);
    check("mid_rst_valid", 64'(id_valid), 64'd0);
    check("mid_rst_pc", id_pc, 64'h0);
    reset = 1'b0; stall = 1'b0; redir_valid = 1'b0;

`ifdef IF_STAGE_PERF_EN
    check("perf_rst_f", 64'(perf_fetched), 64'd0);
    check("perf_rst_r", 64'(perf_redirects), 64'd0);
    for (int i = 0; i < 10; i++) step();
    redir(2'b10, 64'h0, 26'h0, 64'h100);
    step(); step();
    redir_valid = 1'b0;
    check("perf_fetched", 64'(perf_fetched), 64'd10);
    check("perf_redirects", 64'(perf_redirects), 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
